// File: rtl/corr_pkg.sv
// Shared types and arithmetic helpers for the template-correlation scorer.
// Helpers operate at MAX_W bits; callers zero-extend narrower operands.
package corr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_SIM = 1'b0;
    localparam logic MODE_SAD = 1'b1;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] absdiff(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b);
        logic [MAX_W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

    // The extra carry bit lets the sum be compared against the limit without wrapping.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] acc,
                                                 input logic [MAX_W-1:0] term,
                                                 input logic [MAX_W-1:0] limit);
        logic [MAX_W:0]   sum;
        logic [MAX_W-1:0] r;
        sum = {1'b0, acc} + {1'b0, term};
        if (sum > {1'b0, limit}) begin
            r = limit;
        end else begin
            r = sum[MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/corr_rd_align.sv
// Valid pipeline that marks which cycles carry read data for an issued address.
module corr_rd_align #(
    parameter int DEPTH = 2
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] shift_q;

    // Shift the address-valid flag along with the memory read latency.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            shift_q <= {DEPTH{1'b0}};
        end else begin
            shift_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                shift_q[i] <= shift_q[i-1];
            end
        end
    end

    assign valid_o = shift_q[DEPTH-1];

endmodule

// File: rtl/corr_score_engine.sv
// Window-vs-template correlation scorer (similarity or SAD) with a
// start/done handshake and running best-match tracking across runs.
module corr_score_engine
    import corr_pkg::*;
#(
    parameter int PIX_W   = 10,
    parameter int WIN_W   = 64,
    parameter int WIN_H   = 48,
    parameter int COORD_W = 13,
    parameter int RD_LAT  = 2,
    parameter int SCORE_W = 32
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic               iMode,
    input  logic               iClearBest,
    input  logic [COORD_W-1:0] iXstart,
    input  logic [COORD_W-1:0] iYstart,
    output logic [COORD_W-1:0] oX_sram,
    output logic [COORD_W-1:0] oY_sram,
    output logic [COORD_W-1:0] oX_search,
    output logic [COORD_W-1:0] oY_search,
    output logic               oRd_en,
    input  logic [PIX_W-1:0]   reading_sram,
    input  logic [PIX_W-1:0]   reading_search,
    output logic               oBusy,
    output logic               oDone,
    output logic [SCORE_W-1:0] oScore,
    output logic               oBestValid,
    output logic [SCORE_W-1:0] oBestScore,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY
);

    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(WIN_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(WIN_H - 1);
    localparam int                 DCNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DCNT_W-1:0]  D_LAST    = DCNT_W'(RD_LAT - 1);
    localparam logic [MAX_W-1:0]   SAT_LIMIT = MAX_W'({SCORE_W{1'b1}});

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   x_q, y_q, sx_q, sy_q, xs_q, ys_q;
    logic                 mode_q;
    logic [DCNT_W-1:0]    drain_q;
    logic [SCORE_W-1:0]   acc_q, acc_d;
    logic [SCORE_W-1:0]   score_q, best_score_q;
    logic [COORD_W-1:0]   best_x_q, best_y_q;
    logic                 done_q, best_valid_q;
    logic                 busy_s, rd_en_s, valid_s, last_addr_s, finish_s, better_s;
    logic [MAX_W-1:0]     ad_full_s, acc_sum_s, unused_bits_s;
    logic [PIX_W-1:0]     ad_s, term_s;

    corr_rd_align #(
        .DEPTH(RD_LAT)
    ) u_rd_align (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .valid_i(rd_en_s),
        .valid_o(valid_s)
    );

    assign last_addr_s = (x_q == X_LAST) && (y_q == Y_LAST);

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iStart)              state_d = ISSUE; else state_d = IDLE;
            ISSUE:   if (last_addr_s)         state_d = DRAIN; else state_d = ISSUE;
            DRAIN:   if (drain_q == D_LAST)   state_d = DONE;  else state_d = DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_s  = 1'b0;
        rd_en_s = 1'b0;
        case (state_q)
            IDLE:    busy_s = 1'b0;
            ISSUE:   begin busy_s = 1'b1; rd_en_s = 1'b1; end
            DRAIN:   busy_s = 1'b1;
            DONE:    busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Raster address counters; frame addresses wrap at COORD_W bits.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            x_q     <= {COORD_W{1'b0}};
            y_q     <= {COORD_W{1'b0}};
            sx_q    <= {COORD_W{1'b0}};
            sy_q    <= {COORD_W{1'b0}};
            xs_q    <= {COORD_W{1'b0}};
            ys_q    <= {COORD_W{1'b0}};
            mode_q  <= MODE_SIM;
            drain_q <= {DCNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        x_q     <= {COORD_W{1'b0}};
                        y_q     <= {COORD_W{1'b0}};
                        sx_q    <= iXstart;
                        sy_q    <= iYstart;
                        xs_q    <= iXstart;
                        ys_q    <= iYstart;
                        mode_q  <= iMode;
                        drain_q <= {DCNT_W{1'b0}};
                    end else begin
                        mode_q  <= mode_q;
                    end
                end
                ISSUE: begin
                    if (last_addr_s) begin
                        x_q <= x_q;
                    end else if (x_q == X_LAST) begin
                        x_q  <= {COORD_W{1'b0}};
                        sx_q <= xs_q;
                        y_q  <= y_q + COORD_W'(1);
                        sy_q <= sy_q + COORD_W'(1);
                    end else begin
                        x_q  <= x_q + COORD_W'(1);
                        sx_q <= sx_q + COORD_W'(1);
                    end
                end
                DRAIN:   drain_q <= drain_q + DCNT_W'(1);
                default: drain_q <= drain_q;
            endcase
        end
    end

    // Similarity term is (2^PIX_W-1)-|a-b|, i.e. the bitwise inverse of |a-b|.
    assign ad_full_s     = absdiff(MAX_W'(reading_sram), MAX_W'(reading_search));
    assign ad_s          = ad_full_s[PIX_W-1:0];
    assign term_s        = (mode_q == MODE_SAD) ? ad_s : ~ad_s;
    assign acc_sum_s     = sat_add(MAX_W'(acc_q), MAX_W'(term_s), SAT_LIMIT);
    assign unused_bits_s = ad_full_s ^ acc_sum_s;

    // Accumulator next value: cleared on accepted start, else adds aligned terms.
    always_comb begin
        acc_d = acc_q;
        if (state_q == IDLE) begin
            if (iStart) begin
                acc_d = {SCORE_W{1'b0}};
            end else begin
                acc_d = acc_q;
            end
        end else if (valid_s) begin
            acc_d = acc_sum_s[SCORE_W-1:0];
        end else begin
            acc_d = acc_q;
        end
    end

    assign finish_s = (state_q == DRAIN) && (state_d == DONE);
    assign better_s = (mode_q == MODE_SAD) ? (acc_d < best_score_q) : (acc_d > best_score_q);

    // Score capture and best-match tracking; results are valid while oDone is high.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            acc_q        <= {SCORE_W{1'b0}};
            score_q      <= {SCORE_W{1'b0}};
            done_q       <= 1'b0;
            best_valid_q <= 1'b0;
            best_score_q <= {SCORE_W{1'b0}};
            best_x_q     <= {COORD_W{1'b0}};
            best_y_q     <= {COORD_W{1'b0}};
        end else begin
            acc_q <= acc_d;
            if (finish_s) begin
                score_q <= acc_d;
                done_q  <= 1'b1;
                if (!best_valid_q || better_s) begin
                    best_valid_q <= 1'b1;
                    best_score_q <= acc_d;
                    best_x_q     <= xs_q;
                    best_y_q     <= ys_q;
                end else begin
                    best_valid_q <= best_valid_q;
                end
            end else begin
                done_q <= 1'b0;
                if ((state_q == IDLE) && iClearBest) begin
                    best_valid_q <= 1'b0;
                    best_score_q <= {SCORE_W{1'b0}};
                    best_x_q     <= {COORD_W{1'b0}};
                    best_y_q     <= {COORD_W{1'b0}};
                end else begin
                    best_valid_q <= best_valid_q;
                end
            end
        end
    end

    assign oX_sram    = sx_q;
    assign oY_sram    = sy_q;
    assign oX_search  = x_q;
    assign oY_search  = y_q;
    assign oRd_en     = rd_en_s;
    assign oBusy      = busy_s;
    assign oDone      = done_q;
    assign oScore     = score_q;
    assign oBestValid = best_valid_q;
    assign oBestScore = best_score_q;
    assign oBestX     = best_x_q;
    assign oBestY     = best_y_q;

endmodule

// File: tb/tb_corr_score_engine.sv
// Scoreboard bench: a behavioural SRAM/template model feeds two scorers
// (32-bit and 12-bit saturating score) and expected scores are queued per run.
module tb_corr_score_engine;

    localparam int PIX_W    = 10;
    localparam int WIN_W    = 4;
    localparam int WIN_H    = 3;
    localparam int COORD_W  = 13;
    localparam int RD_LAT   = 2;
    localparam int N        = WIN_W * WIN_H;
    localparam int DONE_CYC = N + RD_LAT + 1;

    logic clk = 1'b0;
    logic rst_n, start, mode, clr;
    logic [COORD_W-1:0] xs_in, ys_in;
    logic [COORD_W-1:0] a_xsr, a_ysr, a_xse, a_yse, a_bx, a_by;
    logic [COORD_W-1:0] b_xsr, b_ysr, b_xse, b_yse, b_bx, b_by;
    logic a_rd, a_busy, a_done, a_bv, b_rd, b_busy, b_done, b_bv;
    logic [31:0] a_score, a_bs;
    logic [11:0] b_score, b_bs;
    logic [PIX_W-1:0] sram_p0, sram_p1, srch_p0, srch_p1;

    int n_checks = 0;
    int n_fail   = 0;
    int pat, sram_c, search_c, peak_v, cur_xs, cur_ys;
    int cyc, done_cyc, busy_cnt, rd_cnt;
    int ax [0:31];
    int ay [0:31];
    longint exp_a[$];
    longint exp_b[$];

    always #5 clk = ~clk;

    corr_score_engine #(.PIX_W(PIX_W), .WIN_W(WIN_W), .WIN_H(WIN_H), .COORD_W(COORD_W),
                        .RD_LAT(RD_LAT), .SCORE_W(32)) dut_a (
        .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iMode(mode), .iClearBest(clr),
        .iXstart(xs_in), .iYstart(ys_in), .oX_sram(a_xsr), .oY_sram(a_ysr),
        .oX_search(a_xse), .oY_search(a_yse), .oRd_en(a_rd),
        .reading_sram(sram_p1), .reading_search(srch_p1), .oBusy(a_busy), .oDone(a_done),
        .oScore(a_score), .oBestValid(a_bv), .oBestScore(a_bs), .oBestX(a_bx), .oBestY(a_by));

    corr_score_engine #(.PIX_W(PIX_W), .WIN_W(WIN_W), .WIN_H(WIN_H), .COORD_W(COORD_W),
                        .RD_LAT(RD_LAT), .SCORE_W(12)) dut_b (
        .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iMode(mode), .iClearBest(clr),
        .iXstart(xs_in), .iYstart(ys_in), .oX_sram(b_xsr), .oY_sram(b_ysr),
        .oX_search(b_xse), .oY_search(b_yse), .oRd_en(b_rd),
        .reading_sram(sram_p1), .reading_search(srch_p1), .oBusy(b_busy), .oDone(b_done),
        .oScore(b_score), .oBestValid(b_bv), .oBestScore(b_bs), .oBestX(b_bx), .oBestY(b_by));

    function automatic int frame_pix(int xf, int yf);
        case (pat)
            1:       return (xf * 37 + yf * 101 + 5) % 1024;
            2:       return (xf == cur_xs && yf == cur_ys) ? peak_v : 1023;
            default: return sram_c;
        endcase
    endfunction

    function automatic int tmpl_pix(int x, int y);
        case (pat)
            1:       return (x * 53 + y * 17 + 900) % 1024;
            2:       return 0;
            default: return search_c;
        endcase
    endfunction

    function automatic longint expected_score(int xs, int ys, int md, longint cap);
        longint acc = 0;
        for (int y = 0; y < WIN_H; y++) begin
            for (int x = 0; x < WIN_W; x++) begin
                int a = frame_pix((xs + x) % 8192, (ys + y) % 8192);
                int b = tmpl_pix(x, y);
                int d = (a > b) ? a - b : b - a;
                acc += (md != 0) ? d : 1023 - d;
                if (acc > cap) acc = cap;
            end
        end
        return acc;
    endfunction

    // Two-stage read pipeline matching RD_LAT=2, addressed by dut_a.
    always @(posedge clk) begin
        sram_p0 <= PIX_W'(frame_pix(int'(a_xsr), int'(a_ysr)));
        srch_p0 <= PIX_W'(tmpl_pix(int'(a_xse), int'(a_yse)));
        sram_p1 <= sram_p0;
        srch_p1 <= srch_p0;
    end

    task automatic run_window(input int xs, input int ys, input int md, input int glitch_cyc);
        longint e;
        cur_xs = xs;
        cur_ys = ys;
        exp_a.push_back(expected_score(xs, ys, md, 64'h0000_0000_FFFF_FFFF));
        exp_b.push_back(expected_score(xs, ys, md, 64'd4095));
        xs_in = COORD_W'(xs);
        ys_in = COORD_W'(ys);
        mode  = md[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; done_cyc = 0; busy_cnt = 0; rd_cnt = 0;
        while (cyc < 100 && done_cyc == 0) begin
            if (a_rd) begin
                rd_cnt++;
                if (cyc < 32) begin ax[cyc] = int'(a_xsr); ay[cyc] = int'(a_ysr); end
            end
            if (a_busy) busy_cnt++;
            if (a_done) done_cyc = cyc;
            start = (cyc == glitch_cyc);
            xs_in = (cyc == glitch_cyc) ? COORD_W'(xs + 1) : COORD_W'(xs);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        xs_in = COORD_W'(xs);
        n_checks++;
        if (done_cyc == 0) begin
            n_fail++;
            $display("FAIL done_timeout: no oDone within 100 cycles (xs=%0d ys=%0d)", xs, ys);
        end
        e = exp_a.pop_front();
        n_checks++;
        if (longint'(a_score) !== e) begin
            n_fail++;
            $display("FAIL score32: got %0d expected %0d (xs=%0d ys=%0d mode=%0d)", a_score, e, xs, ys, md);
        end
        e = exp_b.pop_front();
        n_checks++;
        if (longint'(b_score) !== e) begin
            n_fail++;
            $display("FAIL score12: got %0d expected %0d (xs=%0d ys=%0d mode=%0d)", b_score, e, xs, ys, md);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; clr = 1'b0;
        xs_in = '0; ys_in = '0; pat = 0; sram_c = 0; search_c = 0; peak_v = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a_xsr, a_ysr, a_xse, a_yse, a_rd, a_busy, a_done, a_score, a_bv, a_bs, a_bx, a_by} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs score=%h busy=%b rd=%b", a_score, a_busy, a_rd);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identical;
        pat = 0; sram_c = 300; search_c = 300;
        run_window(0, 0, 0, 0);
        n_checks++;
        if (a_score !== 32'd12276) begin n_fail++; $display("FAIL ident_sim: got %0d expected 12276", a_score); end
        n_checks++;
        if (b_score !== 12'd4095) begin n_fail++; $display("FAIL ident_sat12: got %0d expected 4095", b_score); end
        n_checks++;
        if (done_cyc !== DONE_CYC) begin n_fail++; $display("FAIL done_cycle: got %0d expected %0d", done_cyc, DONE_CYC); end
        n_checks++;
        if (busy_cnt !== DONE_CYC) begin n_fail++; $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, DONE_CYC); end
        n_checks++;
        if (rd_cnt !== N) begin n_fail++; $display("FAIL rd_en_cycles: got %0d expected %0d", rd_cnt, N); end
        n_checks++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b expected 0", a_busy); end
        run_window(0, 0, 1, 0);
        n_checks++;
        if (a_score !== 32'd0) begin n_fail++; $display("FAIL ident_sad: got %0d expected 0", a_score); end
    endtask

    task automatic test_sad_sim;
        pat = 0; sram_c = 100; search_c = 40;
        run_window(0, 0, 1, 0);
        n_checks++;
        if (a_score !== 32'd720) begin n_fail++; $display("FAIL sad_100_40: got %0d expected 720", a_score); end
        run_window(0, 0, 0, 0);
        n_checks++;
        if (a_score !== 32'd11556) begin n_fail++; $display("FAIL sim_100_40: got %0d expected 11556", a_score); end
        sram_c = 40; search_c = 100;
        run_window(0, 0, 1, 0);
        n_checks++;
        if (a_score !== 32'd720) begin n_fail++; $display("FAIL sad_40_100: got %0d expected 720", a_score); end
        run_window(0, 0, 0, 0);
        n_checks++;
        if (a_score !== 32'd11556) begin n_fail++; $display("FAIL sim_40_100: got %0d expected 11556", a_score); end
    endtask

    task automatic test_wrap;
        int exp_x [0:3];
        exp_x = '{8190, 8191, 0, 1};
        pat = 1;
        run_window(8190, 8191, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ax[i + 1] !== exp_x[i]) begin
                n_fail++;
                $display("FAIL wrap_x[%0d]: got %0d expected %0d", i, ax[i + 1], exp_x[i]);
            end
        end
        n_checks++;
        if (ay[1] !== 8191 || ay[5] !== 0 || ay[9] !== 1) begin
            n_fail++;
            $display("FAIL wrap_y: got %0d,%0d,%0d expected 8191,0,1", ay[1], ay[5], ay[9]);
        end
    endtask

    task automatic test_best;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        pat = 2; peak_v = 523;
        run_window(1, 1, 0, 0);
        n_checks++;
        if (a_score !== 32'd500 || a_bv !== 1'b1 || a_bs !== 32'd500 || a_bx !== 13'd1 || a_by !== 13'd1) begin
            n_fail++;
            $display("FAIL best_first: got score=%0d valid=%b best=%0d at (%0d,%0d) expected 500 1 500 (1,1)",
                     a_score, a_bv, a_bs, a_bx, a_by);
        end
        peak_v = 123;
        run_window(2, 2, 0, 0);
        run_window(3, 3, 0, 0);
        n_checks++;
        if (a_bv !== 1'b1 || a_bs !== 32'd900 || a_bx !== 13'd2 || a_by !== 13'd2) begin
            n_fail++;
            $display("FAIL best_tie: got valid=%b best=%0d at (%0d,%0d) expected 1 900 (2,2)", a_bv, a_bs, a_bx, a_by);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if (a_bv !== 1'b0 || a_bs !== 32'd0 || a_bx !== 13'd0 || a_by !== 13'd0) begin
            n_fail++;
            $display("FAIL best_clear: got valid=%b best=%0d at (%0d,%0d) expected 0 0 (0,0)", a_bv, a_bs, a_bx, a_by);
        end
        pat = 0; sram_c = 100; search_c = 40;
        run_window(5, 5, 1, 0);
        sram_c = 40; search_c = 40;
        run_window(6, 6, 1, 0);
        sram_c = 100;
        run_window(7, 7, 1, 0);
        n_checks++;
        if (a_bs !== 32'd0 || a_bx !== 13'd6 || a_by !== 13'd6 || b_bs !== 12'd0) begin
            n_fail++;
            $display("FAIL best_sad_min: got best=%0d at (%0d,%0d) b=%0d expected 0 (6,6) 0", a_bs, a_bx, a_by, b_bs);
        end
    endtask

    task automatic test_reset_mid;
        pat = 1;
        xs_in = 13'd10; ys_in = 13'd20; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (a_rd !== 1'b1) begin n_fail++; $display("FAIL mid_run_rd_en: got %b expected 1", a_rd); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_xsr, a_ysr, a_xse, a_yse, a_rd, a_busy, a_done, a_score, a_bv, a_bs, a_bx, a_by, b_score} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got nonzero outputs score=%h busy=%b rd=%b", a_score, a_busy, a_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_window(10, 20, 0, 0);
        run_window(10, 20, 1, 0);
    endtask

    task automatic test_start_ignored;
        int extra = 0;
        pat = 1;
        run_window(3, 4, 1, 4);
        n_checks++;
        if (done_cyc !== DONE_CYC) begin n_fail++; $display("FAIL glitch_done_cycle: got %0d expected %0d", done_cyc, DONE_CYC); end
        for (int i = 0; i < 20; i++) begin
            if (a_done) extra++;
            @(negedge clk);
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL glitch_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_back_to_back;
        pat = 1;
        for (int i = 0; i < 3; i++) begin
            run_window(100 + i * 3, 50 + i, i % 2, 0);
            n_checks++;
            if (done_cyc !== DONE_CYC) begin
                n_fail++;
                $display("FAIL b2b_done_cycle[%0d]: got %0d expected %0d", i, done_cyc, DONE_CYC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identical();
        test_sad_sim();
        test_wrap();
        test_best();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
